// File: rtl/comando_contador.sv
// comando_contador: turns bouncing buttons and switches into clean,
// single-cycle up/down/load commands with auto-repeat for up/down.
module comando_contador #(
    parameter int DEBOUNCE      = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_load,
    input  logic [5:0] chaves,
    output logic [1:0] operacao,
    output logic [5:0] valor
);

    localparam int DW   = $clog2(DEBOUNCE + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        WAIT_REL
    } state_e;

    // bit 0 = up, bit 1 = down, bit 2 = load
    logic [2:0] btn_raw;
    assign btn_raw = {btn_load, btn_down, btn_up};

    logic [2:0]    bs1_q, bs2_q;
    logic [5:0]    cs1_q, cs2_q;
    logic [1:0]    vld_q;
    logic [2:0]    db_q, db_d;
    logic [2:0]    dbp_q;
    logic [2:0]    arm_q, arm_d;
    logic [DW-1:0] dcnt_q [3];
    logic [DW-1:0] dcnt_d [3];
    logic [2:0]    press;

    state_e        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          dn_q, dn_d;
    logic [1:0]    op_q, op_d;
    logic [5:0]    val_q, val_d;
    logic          act_db;
    logic [1:0]    act_op;

    // Two-flop synchronizers for buttons and switches
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bs1_q <= '0;
            bs2_q <= '0;
            cs1_q <= '0;
            cs2_q <= '0;
        end else begin
            bs1_q <= btn_raw;
            bs2_q <= bs1_q;
            cs1_q <= chaves;
            cs2_q <= cs1_q;
        end
    end

    // Debounce counters; a button is armed only after a genuine low is
    // seen, so a button held through reset never fires on its own
    always_comb begin
        db_d  = db_q;
        arm_d = arm_q;
        for (int i = 0; i < 3; i++) begin
            dcnt_d[i] = '0;
            if (bs2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE - 1)) begin
                    db_d[i] = bs2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
            if (vld_q[1] && !db_q[i] && !bs2_q[i]) begin
                arm_d[i] = 1'b1;
            end
        end
    end

    // Debounced levels, edge history, arming and sync-valid tracking
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            db_q  <= '0;
            dbp_q <= '0;
            arm_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            db_q  <= db_d;
            dbp_q <= db_q;
            arm_q <= arm_d;
            vld_q <= {vld_q[0], 1'b1};
            for (int i = 0; i < 3; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

    assign press  = db_q & ~dbp_q & arm_q;
    assign act_db = dn_q ? db_q[1] : db_q[0];
    assign act_op = dn_q ? OP_DEC : OP_INC;

    // Command FSM: next state, repeat timing and pulse generation
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        dn_d    = dn_q;
        op_d    = OP_HOLD;
        val_d   = val_q;
        unique case (state_q)
            IDLE: begin
                rcnt_d = '0;
                if (press[2]) begin
                    op_d    = OP_LOAD;
                    val_d   = cs2_q;
                    state_d = WAIT_REL;
                end else if (press[0]) begin
                    op_d    = OP_INC;
                    dn_d    = 1'b0;
                    state_d = DELAY;
                end else if (press[1]) begin
                    op_d    = OP_DEC;
                    dn_d    = 1'b1;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (!act_db) begin
                    rcnt_d  = '0;
                    state_d = IDLE;
                end else if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
                    op_d    = act_op;
                    rcnt_d  = '0;
                    state_d = REPEAT;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!act_db) begin
                    rcnt_d  = '0;
                    state_d = IDLE;
                end else if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
                    op_d   = act_op;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!db_q[2]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered command outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            dn_q    <= 1'b0;
            op_q    <= OP_HOLD;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            dn_q    <= dn_d;
            op_q    <= op_d;
            val_q   <= val_d;
        end
    end

    assign operacao = op_q;
    assign valor    = val_q;

endmodule

// File: tb/tb_comando_contador.sv
// tb_comando_contador: scoreboard bench; expected pulses are queued
// with their edge number when buttons are driven, popped on output.
module tb_comando_contador;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  op;
        logic [5:0]  val;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       btn_up, btn_down, btn_load;
    logic [5:0] chaves;
    logic [1:0] operacao;
    logic [5:0] valor;

    int unsigned cyc = 0;
    int          errs = 0;
    int          checks = 0;
    int unsigned base;
    exp_t        sb[$];

    comando_contador #(
        .DEBOUNCE     (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .btn_load(btn_load),
        .chaves  (chaves),
        .operacao(operacao),
        .valor   (valor)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int unsigned c, input logic [1:0] op,
                        input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.op  = op;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every non-hold cycle must match the head of the scoreboard
    always @(negedge clk) begin
        if (operacao !== 2'b11) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(operacao), 32'd3);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_op", 32'(operacao), 32'(e.op));
                if (e.op == 2'b10) begin
                    check("pulse_valor", 32'(valor), 32'(e.val));
                end
            end
        end
    end

    initial begin
        clr_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_load = 1'b0;
        chaves   = 6'd0;

        // reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            btn_up   = i[0];
            btn_down = ~i[0];
            btn_load = i[1];
            chaves   = 6'(i * 13 + 7);
            #1;
            check("rst_op", 32'(operacao), 32'd3);
            check("rst_val", 32'(valor), 32'd0);
        end
        @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_load = 1'b0;
        chaves   = 6'd0;
        clr_n    = 1'b1;
        tick(8);
        check("post_rst_op", 32'(operacao), 32'd3);

        // clean press; release lands exactly on the first repeat slot
        btn_up = 1'b1;
        base   = cyc;
        push(base + 7, 2'b00, 6'd0);
        tick(10);
        btn_up = 1'b0;
        tick(25);
        check("clean_pending", 32'(sb.size()), 32'd0);

        // bounce: short high runs, then stable
        for (int r = 0; r < 2; r++) begin
            btn_down = 1'b1;
            tick(3);
            btn_down = 1'b0;
            tick(3);
        end
        btn_down = 1'b1;
        base     = cyc;
        push(base + 7, 2'b01, 6'd0);
        tick(8);
        btn_down = 1'b0;
        tick(25);
        check("bounce_pending", 32'(sb.size()), 32'd0);

        // auto-repeat
        btn_up = 1'b1;
        base   = cyc;
        push(base + 7, 2'b00, 6'd0);
        for (int k = 0; k < 6; k++) begin
            push(base + 7 + RD + k * RP, 2'b00, 6'd0);
        end
        tick(40);
        btn_up = 1'b0;
        tick(25);
        check("repeat_pending", 32'(sb.size()), 32'd0);

        // load wins over a simultaneous up press
        chaves = 6'd42;
        tick(4);
        btn_load = 1'b1;
        btn_up   = 1'b1;
        base     = cyc;
        push(base + 7, 2'b10, 6'd42);
        tick(10);
        chaves = 6'd5;
        tick(10);
        check("load_hold_val", 32'(valor), 32'd42);
        btn_load = 1'b0;
        btn_up   = 1'b0;
        tick(15);
        check("load1_pending", 32'(sb.size()), 32'd0);
        btn_load = 1'b1;
        base     = cyc;
        push(base + 7, 2'b10, 6'd5);
        tick(10);
        btn_load = 1'b0;
        tick(15);
        check("load2_pending", 32'(sb.size()), 32'd0);
        check("load2_val", 32'(valor), 32'd5);

        // reset in REPEAT, button held across release
        btn_up = 1'b1;
        base   = cyc;
        push(base + 7, 2'b00, 6'd0);
        push(base + 7 + RD, 2'b00, 6'd0);
        tick(19);
        clr_n = 1'b0;
        #1;
        check("midrst_op", 32'(operacao), 32'd3);
        check("midrst_val", 32'(valor), 32'd0);
        check("midrst_pending", 32'(sb.size()), 32'd0);
        tick(3);
        clr_n = 1'b1;
        tick(30);
        check("held_after_rst", 32'(sb.size()), 32'd0);
        btn_up = 1'b0;
        tick(15);
        btn_up = 1'b1;
        base   = cyc;
        push(base + 7, 2'b00, 6'd0);
        tick(8);
        btn_up = 1'b0;
        tick(25);
        check("repress_pending", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/comando_contador.md
# comando_contador

Front-end command generator for the 6-bit up/down/load counter. Converts three raw, bouncing push-buttons and six slide switches into clean, single-cycle counter commands (`operacao`, `valor`). It drives `operacao = 2'b11` (hold) except in the exact cycles where a step or load must occur. Auto-repeat is provided for up/down while a button is held.

## Interface
- `DEBOUNCE`, 500000: consecutive stable cycles required to accept a button level change (10 ms @ 50 MHz); minimum 2.
- `REPEAT_DELAY`, 25000000: cycles from the first up/down pulse to the first repeat pulse; minimum 2.
- `REPEAT_PERIOD`, 5000000: cycles between successive repeat pulses; minimum 2.
- `clk`  in  1  single system clock; all state on rising edge.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `btn_up`  in  1  raw button, active-high, asynchronous to `clk`.
- `btn_down`  in  1  raw button, active-high, asynchronous.
- `btn_load`  in  1  raw button, active-high, asynchronous.
- `chaves`  in  6  raw switch value for load, asynchronous.
- `operacao`  out  2  command: 00 increment, 01 decrement, 10 load, 11 hold.
- `valor`  out  6  load value, valid whenever `operacao = 10`.

## Operation
- Reset (asynchronous, `clr_n` low) forces:
  - `operacao = 11`, `valor = 0`.
  - All synchronizers, debounced levels and debounce/repeat counters to 0.
  - FSM to IDLE.
- Synchronization:
  - Each button and each `chaves` bit passes through a two-flop synchronizer before use.
- Debounce, per button:
  - The debounced level `db` changes only after the synchronized input has differed from `db` for `DEBOUNCE` consecutive cycles.
  - Any cycle with agreement clears that button's counter.
- Press event: `db` rising 0→1.
- Release: `db` = 0.
- FSM states:
  - IDLE:
    - A press event issues a command pulse, one cycle, with priority load > up > down.
    - Load goes to WAIT_REL.
    - Up or down goes to DELAY and records the active button.
    - Simultaneous press events on lower-priority buttons are discarded.
  - DELAY:
    - Counts `REPEAT_DELAY` cycles from the pulse.
    - At terminal count, issues a pulse of the active command and enters REPEAT.
    - Release of the active button returns to IDLE immediately, with no pulse.
  - REPEAT:
    - Issues a pulse of the active command every `REPEAT_PERIOD` cycles.
    - Release returns to IDLE.
  - WAIT_REL: no pulses; returns to IDLE when `db_load` = 0.
- Press events on non-active buttons in DELAY, REPEAT or WAIT_REL are ignored and are not queued.
- A button still held when the FSM returns to IDLE does not generate a pulse until it is released and pressed again.
- `valor` captures the synchronized `chaves` on the same edge that asserts a load pulse, and holds until the next load. Switch changes at other times do not affect `valor`.
- `operacao` is registered; every pulse is exactly one cycle of 00, 01 or 10, followed by 11.
- Never two consecutive non-11 cycles, since `REPEAT_PERIOD` and `REPEAT_DELAY` ≥ 2.
- Reset asserted mid-operation aborts any state immediately: outputs return to reset values asynchronously, and no pulse is emitted on release of reset.

## Timing
- Edge 1 is the first clock edge sampling a raw button high, with the button held stable afterwards:
  - Synchronized high after edge 2.
  - `db` rises at edge `DEBOUNCE+2`.
  - `operacao` pulse is visible from edge `DEBOUNCE+3` until edge `DEBOUNCE+4`.
- First repeat pulse is asserted `REPEAT_DELAY` edges after the first pulse edge. Subsequent pulses follow every `REPEAT_PERIOD` edges.
- Release latency: `db` falls `DEBOUNCE+2` edges after the raw input falls, and the FSM leaves its state on the following edge. A repeat pulse due on that same edge is suppressed.
- `chaves` path latency to `valor`: the 2-flop synchronizer plus the load pulse edge.
- Glitches shorter than `DEBOUNCE` cycles after synchronization produce no pulse.

## Test plan
- Reset: hold `clr_n` low with buttons toggling → `operacao = 11` and `valor = 0` throughout. Release → still 11.
- Clean press, `DEBOUNCE=4`: `btn_up` high from edge 1 and held 3 cycles past the pulse, then released → `operacao = 00` for exactly the cycle after edge 7; 11 otherwise; FSM ends in IDLE.
- Bounce: `btn_down` toggled with high runs of 3 cycles (at `DEBOUNCE=4`), then stable high → exactly one `01` pulse, 7 edges after the start of the stable run.
- Auto-repeat, `DEBOUNCE=4`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=5`: hold `btn_up` for 40 cycles → 00 pulses at edges 7, 17, 22, 27, 32, 37, 42. No pulse after the debounced release.
- Load with priority: `chaves = 6'd42`, press `btn_load` and `btn_up` on the same edge → single `operacao = 10` with `valor = 42`, no `00`. Change `chaves` to 5 while held → `valor` stays 42. Release and re-press load → `valor = 5`.
- Mid-operation reset: assert `clr_n` low while in REPEAT → outputs drop to 11/0 within the same cycle, without waiting for a clock edge. After release with the button still held → no pulse until the button is released and pressed again.
